servo_cmd_ctrl: RTL

SERVO_CMD_CTRL -- requirements
Module: servo_cmd_ctrl

---
 rtl/servo_cmd_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/servo_cmd_ctrl.sv
// servo_cmd_ctrl: two-button servo position commander with debounce and auto-repeat.
// Optional SERVO_CMD_HOME_EN: holding both buttons in lock homes position to MID_POS.
module servo_cmd_ctrl #(
    parameter int DEB_CYCLES    = 500000,
    parameter int REPEAT_CYCLES = 25000000,
    parameter int STEP          = 1000,
    parameter int MAX_POS       = 50000,
    parameter int MID_POS       = 25000
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_dn,
    output logic [15:0] position,
    output logic        pos_valid,
    output logic        dir,
    output logic        at_limit
);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_TC = DEB_W'(DEB_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_TC = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [16:0] STEP17 = 17'(STEP);
    localparam logic [16:0] MAX17  = 17'(MAX_POS);
    localparam logic [15:0] MAX16  = 16'(MAX_POS);
`ifdef SERVO_CMD_HOME_EN
    localparam logic [15:0] MID16  = 16'(MID_POS);
`endif

    typedef enum logic [1:0] {
        IDLE,
        UP_HOLD,
        DN_HOLD,
        BOTH_LOCK
    } state_t;

    // Bit 0 is the up button, bit 1 the down button.
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       deb;
    logic [1:0]       deb_q;
    logic [DEB_W-1:0] deb_cnt [2];

    state_t           state;
    logic [REP_W-1:0] rep_cnt;
`ifdef SERVO_CMD_HOME_EN
    logic [REP_W-1:0] home_cnt;
    logic             home_done;
`endif

    logic        up_rise;
    logic        dn_rise;
    logic [16:0] up_sum;
    logic [16:0] dn_diff;
    logic [15:0] up_pos;
    logic [15:0] dn_pos;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= {btn_dn, btn_up};
            sync2 <= sync1;
            deb_q <= deb;
            // A sample matching the current level restarts the count.
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_TC) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    assign up_rise = deb[0] & ~deb_q[0];
    assign dn_rise = deb[1] & ~deb_q[1];

    always_comb begin
        up_sum  = {1'b0, position} + STEP17;
        dn_diff = {1'b0, position} - STEP17;
        up_pos  = (up_sum > MAX17) ? MAX16 : up_sum[15:0];
        dn_pos  = dn_diff[16] ? 16'd0 : dn_diff[15:0];
    end

    assign at_limit = (position == 16'd0) || (position == MAX16);

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            position  <= '0;
            pos_valid <= 1'b0;
            dir       <= 1'b1;
            rep_cnt   <= '0;
`ifdef SERVO_CMD_HOME_EN
            home_cnt  <= '0;
            home_done <= 1'b0;
`endif
        end else begin
            pos_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    rep_cnt <= '0;
`ifdef SERVO_CMD_HOME_EN
                    home_cnt  <= '0;
                    home_done <= 1'b0;
`endif
                    if (up_rise && (dn_rise || deb[1])) begin
                        state <= BOTH_LOCK;
                    end else if (dn_rise && deb[0]) begin
                        state <= BOTH_LOCK;
                    end else if (up_rise) begin
                        position  <= up_pos;
                        pos_valid <= (up_pos != position);
                        dir       <= 1'b1;
                        state     <= UP_HOLD;
                    end else if (dn_rise) begin
                        position  <= dn_pos;
                        pos_valid <= (dn_pos != position);
                        dir       <= 1'b0;
                        state     <= DN_HOLD;
                    end
                end
                UP_HOLD: begin
                    if (!deb[0]) begin
                        rep_cnt <= '0;
                        state   <= IDLE;
                    end else if (deb[1]) begin
                        rep_cnt <= '0;
                        state   <= BOTH_LOCK;
                    end else if (rep_cnt == REP_TC) begin
                        rep_cnt   <= '0;
                        position  <= up_pos;
                        pos_valid <= (up_pos != position);
                        dir       <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt + REP_W'(1);
                    end
                end
                DN_HOLD: begin
                    if (!deb[1]) begin
                        rep_cnt <= '0;
                        state   <= IDLE;
                    end else if (deb[0]) begin
                        rep_cnt <= '0;
                        state   <= BOTH_LOCK;
                    end else if (rep_cnt == REP_TC) begin
                        rep_cnt   <= '0;
                        position  <= dn_pos;
                        pos_valid <= (dn_pos != position);
                        dir       <= 1'b0;
                    end else begin
                        rep_cnt <= rep_cnt + REP_W'(1);
                    end
                end
                BOTH_LOCK: begin
                    rep_cnt <= '0;
`ifdef SERVO_CMD_HOME_EN
                    // Home fires once per lock; it re-arms only via IDLE.
                    if (deb != 2'b11) begin
                        home_cnt <= '0;
                    end else if (!home_done) begin
                        if (home_cnt == REP_TC) begin
                            home_cnt  <= '0;
                            home_done <= 1'b1;
                            position  <= MID16;
                            pos_valid <= (position != MID16);
                        end else begin
                            home_cnt <= home_cnt + REP_W'(1);
                        end
                    end
`endif
                    if (deb == 2'b00) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
